// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the ALU request arbiter.
//   state_t      : arbiter FSM states
//   FLAG_*       : bit positions inside RSP_FLAGS ({ERR,L,E,G,OFLOW,COUT})
//   is_mul_cmd() : identifies the long-latency arithmetic commands
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int FLAG_COUT  = 0;
    localparam int FLAG_OFLOW = 1;
    localparam int FLAG_G     = 2;
    localparam int FLAG_E     = 3;
    localparam int FLAG_L     = 4;
    localparam int FLAG_ERR   = 5;
    localparam int NFLAGS     = 6;

    // Arithmetic CMD 9/A use pipelined temporaries inside the ALU and need
    // one extra cycle before RES is valid.
    function automatic logic is_mul_cmd(input logic mode, input logic [3:0] cmd);
        return mode && ((cmd == 4'h9) || (cmd == 4'hA));
    endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Combinational round-robin priority picker.
//   valid     in  NREQ  request vector
//   rr_ptr    in  IW    index with highest priority this round
//   grant     out NREQ  one-hot grant (all zero when nothing valid)
//   grant_idx out IW    index of the granted requester
//   any_valid out 1     at least one request is valid
module alu_rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any_valid
);

    int idx;

    // Walk rr_ptr..NREQ-1 then 0..rr_ptr-1; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int off = 0; off < NREQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_valid && valid[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between NREQ requesters, one operation in flight at a time.
//   CLK, RST_N                    clock, async active-low reset
//   REQ_VALID/READY               per-requester handshake (READY one-hot, IDLE only)
//   REQ_OPA/OPB/CMD/MODE/CIN      packed per-requester payload
//   ALU_RST, ALU_CE               ALU sync reset and clock enable
//   ALU_INP_VALID, ALU_OPA..CIN   issued operation (payload held until IDLE)
//   ALU_RES, ALU_COUT..ALU_ERR    ALU result and flags (may be z)
//   RSP_VALID/READY, RSP_ID       response handshake and requester tag
//   RSP_RES, RSP_FLAGS            sampled result/flags with non-1 bits cleared
//   BUSY                          high whenever an op is being serviced
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int NREQ    = 4,
    parameter int LAT_STD = 2,
    parameter int LAT_MUL = 3
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NREQ-1:0]         REQ_VALID,
    output logic [NREQ-1:0]         REQ_READY,
    input  logic [NREQ*DW-1:0]      REQ_OPA,
    input  logic [NREQ*DW-1:0]      REQ_OPB,
    input  logic [NREQ*CW-1:0]      REQ_CMD,
    input  logic [NREQ-1:0]         REQ_MODE,
    input  logic [NREQ-1:0]         REQ_CIN,
    output logic                    ALU_RST,
    output logic                    ALU_CE,
    output logic [1:0]              ALU_INP_VALID,
    output logic [DW-1:0]           ALU_OPA,
    output logic [DW-1:0]           ALU_OPB,
    output logic [CW-1:0]           ALU_CMD,
    output logic                    ALU_MODE,
    output logic                    ALU_CIN,
    input  logic [DW+1:0]           ALU_RES,
    input  logic                    ALU_COUT,
    input  logic                    ALU_OFLOW,
    input  logic                    ALU_G,
    input  logic                    ALU_E,
    input  logic                    ALU_L,
    input  logic                    ALU_ERR,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [$clog2(NREQ)-1:0] RSP_ID,
    output logic [DW+1:0]           RSP_RES,
    output logic [NFLAGS-1:0]       RSP_FLAGS,
    output logic                    BUSY
);

    localparam int IW     = $clog2(NREQ);
    localparam int LAT_MX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
    localparam int CNTW   = $clog2(LAT_MX + 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   id;
    logic [CNTW-1:0] cnt;
    logic            alu_rst_q;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            any_valid;

    // The ALU input bus may float; only a solid 1 counts as 1.
    function automatic logic [DW+1:0] clean_res(input logic [DW+1:0] v);
        logic [DW+1:0] r;
        for (int i = 0; i < DW + 2; i++) r[i] = (v[i] === 1'b1);
        return r;
    endfunction

    function automatic logic one(input logic b);
        return (b === 1'b1);
    endfunction

    alu_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .valid     (REQ_VALID),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    // Two-stage release so the ALU sees reset for one full clock after RST_N rises.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_rst_q <= 1'b1;
            ALU_RST   <= 1'b1;
        end else begin
            alu_rst_q <= 1'b0;
            ALU_RST   <= alu_rst_q;
        end
    end

    assign ALU_CE = ~ALU_RST;
    assign BUSY   = (state != IDLE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // READY is gated by RST_N so nothing is granted while reset is held.
    always_comb begin
        state_nxt     = state;
        REQ_READY     = '0;
        ALU_INP_VALID = 2'b00;
        case (state)
            IDLE: begin
                if (any_valid && RST_N) begin
                    REQ_READY = grant;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                ALU_INP_VALID = 2'b11;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (cnt == CNTW'(1)) state_nxt = RESP;
            end
            RESP: begin
                if (RSP_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr    <= '0;
            id        <= '0;
            cnt       <= '0;
            ALU_OPA   <= '0;
            ALU_OPB   <= '0;
            ALU_CMD   <= '0;
            ALU_MODE  <= 1'b0;
            ALU_CIN   <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_RES   <= '0;
            RSP_FLAGS <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        ALU_OPA  <= REQ_OPA[grant_idx*DW +: DW];
                        ALU_OPB  <= REQ_OPB[grant_idx*DW +: DW];
                        ALU_CMD  <= REQ_CMD[grant_idx*CW +: CW];
                        ALU_MODE <= REQ_MODE[grant_idx];
                        ALU_CIN  <= REQ_CIN[grant_idx];
                        id       <= grant_idx;
                    end
                end
                ISSUE: begin
                    cnt <= is_mul_cmd(ALU_MODE, 4'(ALU_CMD)) ? CNTW'(LAT_MUL) : CNTW'(LAT_STD);
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNTW'(1)) begin
                        RSP_RES              <= clean_res(ALU_RES);
                        RSP_FLAGS[FLAG_COUT]  <= one(ALU_COUT);
                        RSP_FLAGS[FLAG_OFLOW] <= one(ALU_OFLOW);
                        RSP_FLAGS[FLAG_G]     <= one(ALU_G);
                        RSP_FLAGS[FLAG_E]     <= one(ALU_E);
                        RSP_FLAGS[FLAG_L]     <= one(ALU_L);
                        RSP_FLAGS[FLAG_ERR]   <= one(ALU_ERR);
                        RSP_ID               <= id;
                        RSP_VALID            <= 1'b1;
                    end
                end
                RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        if (int'(id) == NREQ - 1) rr_ptr <= '0;
                        else                      rr_ptr <= id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
    import alu_arb_pkg::*;

    localparam int DW = 8, CW = 4, NREQ = 4, LAT_STD = 2, LAT_MUL = 3, IW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready, req_mode, req_cin;
    logic [NREQ*DW-1:0] req_opa, req_opb;
    logic [NREQ*CW-1:0] req_cmd;
    logic              alu_rst, alu_ce, alu_mode, alu_cin;
    logic [1:0]        alu_inp_valid;
    logic [DW-1:0]     alu_opa, alu_opb;
    logic [CW-1:0]     alu_cmd;
    logic [15:0]       alu_raw_bus;
    logic              rsp_valid, rsp_ready, busy;
    logic [IW-1:0]     rsp_id;
    logic [DW+1:0]     rsp_res;
    logic [5:0]        rsp_flags;

    typedef struct {
        logic [IW-1:0] id;
        logic [9:0]    res;
        logic [5:0]    flags;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Behavioural ALU stand-in: {flags[5:0], res[9:0]}, undriven bits left z.
    function automatic logic [15:0] alu_raw(input logic mode, input logic [3:0] cmd,
                                            input logic [7:0] a, input logic [7:0] b,
                                            input logic cin);
        logic [9:0] r;
        logic [5:0] f;
        logic [8:0] s;
        r = 'z;
        f = 'z;
        s = '0;
        if (mode) begin
            case (cmd)
                4'h0: begin s = {1'b0, a} + {1'b0, b}; r = {1'b0, s}; f[0] = s[8]; end
                4'h1: begin r = {2'b00, a - b}; f[1] = (a < b); end
                4'h2: begin s = {1'b0, a} + {1'b0, b} + {8'b0, cin}; r = {1'b0, s}; f[0] = s[8]; end
                4'h8: begin f[2] = (a > b); f[3] = (a == b); f[4] = (a < b); end
                4'h9: r = ({2'b00, a} + 10'd1) * ({2'b00, b} + 10'd1);
                default: ;
            endcase
        end else begin
            case (cmd)
                4'h0: r = {2'b00, a & b};
                4'h1: r = {2'b00, a | b};
                4'h2: r = {2'b00, a ^ b};
                default: ;
            endcase
        end
        return {f, r};
    endfunction

    function automatic exp_t expect_of(input int id, input logic mode, input logic [3:0] cmd,
                                       input logic [7:0] a, input logic [7:0] b, input logic cin);
        exp_t e;
        logic [15:0] raw;
        raw = alu_raw(mode, cmd, a, b, cin);
        e.id = IW'(id);
        for (int i = 0; i < 10; i++) e.res[i] = (raw[i] === 1'b1);
        for (int i = 0; i < 6; i++)  e.flags[i] = (raw[10+i] === 1'b1);
        return e;
    endfunction

    assign alu_raw_bus = alu_raw(alu_mode, alu_cmd, alu_opa, alu_opb, alu_cin);

    alu_req_arbiter #(.DW(DW), .CW(CW), .NREQ(NREQ), .LAT_STD(LAT_STD), .LAT_MUL(LAT_MUL)) dut (
        .CLK(clk), .RST_N(rst_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_OPA(req_opa), .REQ_OPB(req_opb), .REQ_CMD(req_cmd),
        .REQ_MODE(req_mode), .REQ_CIN(req_cin),
        .ALU_RST(alu_rst), .ALU_CE(alu_ce), .ALU_INP_VALID(alu_inp_valid),
        .ALU_OPA(alu_opa), .ALU_OPB(alu_opb), .ALU_CMD(alu_cmd),
        .ALU_MODE(alu_mode), .ALU_CIN(alu_cin),
        .ALU_RES(alu_raw_bus[9:0]),
        .ALU_COUT(alu_raw_bus[10]), .ALU_OFLOW(alu_raw_bus[11]), .ALU_G(alu_raw_bus[12]),
        .ALU_E(alu_raw_bus[13]), .ALU_L(alu_raw_bus[14]), .ALU_ERR(alu_raw_bus[15]),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_ID(rsp_id),
        .RSP_RES(rsp_res), .RSP_FLAGS(rsp_flags), .BUSY(busy)
    );

    task automatic set_req(input int i, input logic mode, input logic [3:0] cmd,
                           input logic [7:0] a, input logic [7:0] b, input logic cin);
        req_opa[i*DW +: DW] = a;
        req_opb[i*DW +: DW] = b;
        req_cmd[i*CW +: CW] = cmd;
        req_mode[i]         = mode;
        req_cin[i]          = cin;
        req_valid[i]        = 1'b1;
    endtask

    // Returns just after the accept edge (ok=1) or after the budget expires.
    task automatic wait_accept(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (req_ready[i]) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // Counts falling edges until RSP_VALID is seen high.
    task automatic wait_rsp(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 4'b0101;
        repeat (2) @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 ||
            alu_inp_valid !== 2'b00 || alu_rst !== 1'b1 || alu_ce !== 1'b0 ||
            rsp_res !== 10'h0 || rsp_flags !== 6'h0 || alu_opa !== 8'h0) begin
            fails++;
            $display("FAIL reset_state: vld=%b busy=%b rdy=%b iv=%b rst=%b ce=%b res=%h fl=%b opa=%h, need 0 0 0000 00 1 0 0 0 0",
                     rsp_valid, busy, req_ready, alu_inp_valid, alu_rst, alu_ce, rsp_res, rsp_flags, alu_opa);
        end
        req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (alu_rst !== 1'b1) begin
            fails++;
            $display("FAIL alu_rst_edge1: got %b need 1", alu_rst);
        end
        @(posedge clk); #1;
        tests++;
        if (alu_rst !== 1'b0 || alu_ce !== 1'b1) begin
            fails++;
            $display("FAIL alu_rst_edge2: rst=%b ce=%b need 0 1", alu_rst, alu_ce);
        end
        @(negedge clk);
    endtask

    task automatic test_single_op;
        bit ok; int cyc; exp_t e;
        set_req(0, 1'b1, 4'h0, 8'hFF, 8'h01, 1'b0);
        wait_accept(0, ok);
        req_valid = '0;
        if (ok) sb.push_back(expect_of(0, 1'b1, 4'h0, 8'hFF, 8'h01, 1'b0));
        @(negedge clk);
        tests++;
        if (!ok || alu_inp_valid !== 2'b11 || alu_opa !== 8'hFF || alu_opb !== 8'h01 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_issue: ok=%0d iv=%b opa=%h opb=%h busy=%b need 1 11 ff 01 1",
                     ok, alu_inp_valid, alu_opa, alu_opb, busy);
        end
        wait_rsp(cyc, ok);
        tests++;
        if (!ok || cyc + 1 != 4) begin
            fails++;
            $display("FAIL single_latency: ok=%0d cycles=%0d need 4", ok, cyc + 1);
        end
        e = sb.pop_front();
        tests++;
        if (rsp_id !== e.id || rsp_res !== e.res || rsp_flags !== e.flags ||
            rsp_res !== 10'h100 || rsp_flags[FLAG_COUT] !== 1'b1) begin
            fails++;
            $display("FAIL single_rsp: id=%0d res=%h fl=%b need id=%0d res=%h fl=%b",
                     rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
        end
        @(negedge clk);
        tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_done: vld=%b busy=%b need 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_mul_latency;
        bit ok; int cyc; exp_t e;
        set_req(2, 1'b1, 4'h9, 8'd3, 8'd4, 1'b0);
        wait_accept(2, ok);
        req_valid = '0;
        if (ok) sb.push_back(expect_of(2, 1'b1, 4'h9, 8'd3, 8'd4, 1'b0));
        wait_rsp(cyc, ok);
        tests++;
        if (!ok || cyc != 5) begin
            fails++;
            $display("FAIL mul_latency: ok=%0d cycles=%0d need 5", ok, cyc);
        end
        e = sb.pop_front();
        tests++;
        if (rsp_id !== 2'd2 || rsp_res !== 10'd20 || rsp_res !== e.res || rsp_flags !== e.flags) begin
            fails++;
            $display("FAIL mul_rsp: id=%0d res=%0d fl=%b need id=2 res=20 fl=%b", rsp_id, rsp_res, rsp_flags, e.flags);
        end
        @(negedge clk);
    endtask

    task automatic test_compare_flags;
        bit ok; int cyc; exp_t e;
        logic [3:0] cmds [2] = '{4'h8, 4'hF};
        logic       modes[2] = '{1'b1, 1'b0};
        for (int n = 0; n < 2; n++) begin
            set_req(1, modes[n], cmds[n], 8'd5, 8'd5, 1'b0);
            wait_accept(1, ok);
            req_valid = '0;
            if (ok) sb.push_back(expect_of(1, modes[n], cmds[n], 8'd5, 8'd5, 1'b0));
            wait_rsp(cyc, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || rsp_id !== 2'd1 || rsp_res !== 10'h0 || rsp_flags !== (n == 0 ? 6'b001000 : 6'b000000) ||
                rsp_flags !== e.flags) begin
                fails++;
                $display("FAIL cmp_zflags[%0d]: ok=%0d id=%0d res=%h fl=%b need id=1 res=0 fl=%b",
                         n, ok, rsp_id, rsp_res, rsp_flags, e.flags);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_ops;
        bit ok; int cyc; exp_t e;
        int id; logic mode; logic [3:0] cmd; logic [7:0] a, b; logic cin;
        for (int n = 0; n < 8; n++) begin
            id   = $urandom_range(0, NREQ - 1);
            mode = 1'($urandom_range(0, 1));
            cmd  = (n % 4 == 3) ? 4'h9 : 4'($urandom_range(0, 2));
            a    = 8'($urandom);
            b    = 8'($urandom);
            cin  = 1'($urandom_range(0, 1));
            set_req(id, mode, cmd, a, b, cin);
            wait_accept(id, ok);
            req_valid = '0;
            if (ok) sb.push_back(expect_of(id, mode, cmd, a, b, cin));
            wait_rsp(cyc, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || cyc != ((mode && cmd == 4'h9) ? 5 : 4) ||
                rsp_id !== e.id || rsp_res !== e.res || rsp_flags !== e.flags) begin
                fails++;
                $display("FAIL random_op[%0d]: ok=%0d cyc=%0d id=%0d res=%h fl=%b need id=%0d res=%h fl=%b (m=%b cmd=%h a=%h b=%h)",
                         n, ok, cyc, rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags, mode, cmd, a, b);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op;
        bit ok; bit stale;
        set_req(0, 1'b1, 4'h9, 8'd7, 8'd7, 1'b0);
        wait_accept(0, ok);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        tests++;
        if (!ok || rsp_valid !== 1'b0 || busy !== 1'b0 || alu_rst !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_wait: ok=%0d vld=%b busy=%b alu_rst=%b need 0 0 1", ok, rsp_valid, busy, alu_rst);
        end
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        tests++;
        if (stale || alu_rst !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_stale: stale=%0d alu_rst=%b need 0 0", stale, alu_rst);
        end
    endtask

    task automatic test_round_robin;
        bit ok; int cyc; int g; exp_t e; bit found;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'h0, 8'(i * 16 + 1), 8'(i + 2), 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            found = 1'b0;
            g = -1;
            for (int t = 0; t < 20; t++) begin
                #1;
                if (req_ready != 0) begin found = 1'b1; break; end
                @(negedge clk);
            end
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            tests++;
            if (!found || g != k % NREQ || $countones(req_ready) != 1) begin
                fails++;
                $display("FAIL rr_grant[%0d]: ready=%b need one-hot index %0d", k, req_ready, k % NREQ);
            end
            if (g >= 0) sb.push_back(expect_of(g, 1'b1, 4'h0, 8'(g * 16 + 1), 8'(g + 2), 1'b0));
            @(posedge clk); #1;
            if (k == 4) req_valid = '0;
            wait_rsp(cyc, ok);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if (!ok || rsp_id !== e.id || rsp_res !== e.res || rsp_flags !== e.flags) begin
                    fails++;
                    $display("FAIL rr_rsp[%0d]: id=%0d res=%h fl=%b need id=%0d res=%h fl=%b",
                             k, rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
                end
            end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit ok; int cyc; exp_t e; bit bad;
        logic [9:0] s_res; logic [5:0] s_fl; logic [IW-1:0] s_id; logic [7:0] s_opa;
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 4'h1, 8'd3, 8'd9, 1'b0);
        wait_accept(1, ok);
        req_valid = '0;
        if (ok) sb.push_back(expect_of(1, 1'b1, 4'h1, 8'd3, 8'd9, 1'b0));
        wait_rsp(cyc, ok);
        s_res = rsp_res; s_fl = rsp_flags; s_id = rsp_id; s_opa = alu_opa;
        set_req(3, 1'b0, 4'h2, 8'hA5, 8'h0F, 1'b0);
        set_req(0, 1'b0, 4'h0, 8'hF0, 8'h3C, 1'b0);
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_res !== s_res || rsp_flags !== s_fl || rsp_id !== s_id ||
                alu_opa !== s_opa || req_ready !== 4'b0000) bad = 1'b1;
        end
        tests++;
        if (!ok || bad) begin
            fails++;
            $display("FAIL bp_hold: ok=%0d unstable=%0d vld=%b ready=%b", ok, bad, rsp_valid, req_ready);
        end
        e = sb.pop_front();
        tests++;
        if (rsp_id !== e.id || rsp_res !== e.res || rsp_flags !== e.flags) begin
            fails++;
            $display("FAIL bp_rsp: id=%0d res=%h fl=%b need id=%0d res=%h fl=%b",
                     rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL bp_next_grant: vld=%b ready=%b need 0 1000", rsp_valid, req_ready);
        end
        if (req_ready[3]) sb.push_back(expect_of(3, 1'b0, 4'h2, 8'hA5, 8'h0F, 1'b0));
        @(posedge clk); #1;
        req_valid = '0;
        wait_rsp(cyc, ok);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            tests++;
            if (!ok || rsp_id !== e.id || rsp_res !== e.res || rsp_flags !== e.flags) begin
                fails++;
                $display("FAIL bp_after_rsp: id=%0d res=%h fl=%b need id=%0d res=%h fl=%b",
                         rsp_id, rsp_res, rsp_flags, e.id, e.res, e.flags);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        req_valid = '0; req_opa = '0; req_opb = '0; req_cmd = '0; req_mode = '0; req_cin = '0;
        test_reset();
        test_single_op();
        test_mul_latency();
        test_compare_flags();
        test_random_ops();
        test_reset_mid_op();
        test_round_robin();
        test_backpressure();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_empty: %0d entries left, need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
